// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, widths and parameter defaults for the 7-segment scan controller
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    localparam int SEG_CODE_W     = 3;
    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_PRESCALE   = 50000;

endpackage

// File: rtl/seg7_tick_gen.sv
// rtl/seg7_tick_gen.sv - slot prescaler: one-cycle tick every PRESCALE cycles while run is high
module seg7_tick_gen
    import seg7_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int            CW       = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST_CNT = CW'(PRESCALE - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST_CNT);
    assign tick      = run && w_at_last;

    // Dropping run clears the count so every restart begins a full slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!run || w_at_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment digit scanner with frame-aligned double buffering (option: SEG7_BLANK_GAP_EN)
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int PRESCALE   = DEF_PRESCALE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic                             load_valid,
    input  logic [SEG_CODE_W*NUM_DIGITS-1:0] load_data,
    output logic                             load_ready,
    output logic [SEG_CODE_W-1:0]            enc_sel,
    output logic [NUM_DIGITS-1:0]            digit_en,
    output logic                             frame_done
);

    localparam int            IW       = $clog2(NUM_DIGITS);
    localparam int            DW       = SEG_CODE_W * NUM_DIGITS;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    scan_state_t           r_state;
    logic [IW-1:0]         r_index;
    logic [DW-1:0]         r_disp;
    logic [DW-1:0]         r_pend;
    logic                  r_pend_full;
    logic [NUM_DIGITS-1:0] r_digit_en;
    logic [SEG_CODE_W-1:0] r_enc_sel;

    scan_state_t           w_state_nxt;
    logic [IW-1:0]         w_index_nxt;
    logic [DW-1:0]         w_disp_nxt;
    logic [NUM_DIGITS-1:0] w_digit_en_nxt;
    logic [SEG_CODE_W-1:0] w_enc_sel_nxt;
    logic                  w_run;
    logic                  w_tick;
    logic                  w_boundary;
    logic                  w_xfer;
    logic                  w_apply;

    // Prescaler runs only while staying out of IDLE, so it is zero on every entry to SCAN
    assign w_run = enable && (r_state != IDLE);

    seg7_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .tick  (w_tick)
    );

    assign w_boundary = w_tick && (r_state == SCAN) && (r_index == LAST_IDX);
    assign w_xfer     = load_valid && !r_pend_full;
    // Uses pending_full from before the edge, so a boundary-coincident load waits a frame
    assign w_apply    = r_pend_full && ((r_state == IDLE) || w_boundary);
    assign w_disp_nxt = w_apply ? r_pend : r_disp;

    always_comb begin
        w_state_nxt    = r_state;
        w_index_nxt    = r_index;
        w_digit_en_nxt = '0;
        w_enc_sel_nxt  = '0;
        case (r_state)
            IDLE: begin
                w_index_nxt = '0;
                if (enable) begin
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                    w_index_nxt = '0;
                end else if (w_tick) begin
                    w_index_nxt = (r_index == LAST_IDX) ? '0 : r_index + 1'b1;
`ifdef SEG7_BLANK_GAP_EN
                    w_state_nxt = BLANK;
`endif
                end
            end
`ifdef SEG7_BLANK_GAP_EN
            BLANK: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                    w_index_nxt = '0;
                end else if (w_tick) begin
                    w_state_nxt = SCAN;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
                w_index_nxt = '0;
            end
        endcase
        // Outputs are registered from next-state values so they align with the state register
        if (w_state_nxt == SCAN) begin
            w_digit_en_nxt = NUM_DIGITS'(1) << w_index_nxt;
            w_enc_sel_nxt  = w_disp_nxt[w_index_nxt*SEG_CODE_W +: SEG_CODE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_index    <= '0;
            r_digit_en <= '0;
            r_enc_sel  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_index    <= w_index_nxt;
            r_digit_en <= w_digit_en_nxt;
            r_enc_sel  <= w_enc_sel_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp      <= '0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
        end else begin
            r_disp <= w_disp_nxt;
            if (w_xfer) begin
                r_pend      <= load_data;
                r_pend_full <= 1'b1;
            end else if (w_apply) begin
                r_pend_full <= 1'b0;
            end
        end
    end

    assign load_ready = !r_pend_full;
    assign digit_en   = r_digit_en;
    assign enc_sel    = r_enc_sel;
    assign frame_done = w_boundary;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, PRESCALE=4)
module tb_seg7_scan_ctrl;

`ifdef SEG7_BLANK_GAP_EN
    localparam int FL    = 32;
    localparam int BND   = 27;
    localparam int DROPK = 17;
`else
    localparam int FL    = 16;
    localparam int BND   = 15;
    localparam int DROPK = 9;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic [11:0] load_data;
    logic        load_ready;
    logic [2:0]  enc_sel;
    logic [3:0]  digit_en;
    logic        frame_done;

    int n_checks;
    int n_pass;
    logic [11:0] sched [6];

    seg7_scan_ctrl #(
        .NUM_DIGITS (4),
        .PRESCALE   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .enc_sel    (enc_sel),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // t counts cycles since entry to SCAN at digit 0; codes is the frame expected on display
    task automatic chk_cycle(input int t, input logic [11:0] codes);
        int         k;
        int         slot;
        logic       on;
        logic [3:0] de;
        logic [2:0] es;
        k = t % FL;
`ifdef SEG7_BLANK_GAP_EN
        slot = k / 8;
        on   = (k % 8) < 4;
`else
        slot = k / 4;
        on   = 1'b1;
`endif
        de = on ? 4'(1 << slot) : 4'd0;
        es = on ? codes[slot*3 +: 3] : 3'd0;
        chk("digit_en", 32'(digit_en), 32'(de));
        chk("enc_sel", 32'(enc_sel), 32'(es));
        chk("frame_done", 32'(frame_done), 32'(k == BND));
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        sched      = '{12'o7531, 12'o7531, 12'o0246, 12'o3210, 12'o3210, 12'o4567};
        rst_n      = 1'b1;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;

        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_digit_en", 32'(digit_en), 32'd0);
        chk("rst_enc_sel", 32'(enc_sel), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_digit_en", 32'(digit_en), 32'd0);

        load_valid = 1'b1;
        load_data  = 12'o7531;
        chk("idle_ready", 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0;
        chk("idle_pend_full", 32'(load_ready), 32'd0);
        step();
        chk("idle_applied", 32'(load_ready), 32'd1);
        chk("idle_enc_sel", 32'(enc_sel), 32'd0);
        enable = 1'b1;
        step();

        for (int t = 0; t <= 5*FL + DROPK; t++) begin
            chk_cycle(t, sched[t / FL]);
            if (t == FL + 6) begin
                load_valid = 1'b1;
                load_data  = 12'o0246;
            end
            if (t >= FL + 7 && t <= FL + BND) begin
                chk("ready_stall", 32'(load_ready), 32'd0);
                load_data = 12'o3210;
            end
            if (t == FL + BND + 1) chk("ready_reopen", 32'(load_ready), 32'd1);
            if (t == FL + BND + 2) begin
                chk("ready_third", 32'(load_ready), 32'd0);
                load_valid = 1'b0;
            end
            if (t == 3*FL + BND) begin
                chk("ready_pre_bnd", 32'(load_ready), 32'd1);
                load_valid = 1'b1;
                load_data  = 12'o4567;
            end
            if (t == 3*FL + BND + 1) begin
                chk("ready_bnd_load", 32'(load_ready), 32'd0);
                load_valid = 1'b0;
            end
            if (t == 5*FL + DROPK) enable = 1'b0;
            step();
        end

        chk("drop_digit_en", 32'(digit_en), 32'd0);
        chk("drop_enc_sel", 32'(enc_sel), 32'd0);
        chk("drop_frame_done", 32'(frame_done), 32'd0);
        chk("drop_ready", 32'(load_ready), 32'd1);
        enable = 1'b1;
        step();
        for (int t = 0; t <= FL; t++) begin
            chk_cycle(t, 12'o4567);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
